// File: rtl/dm_arb_pkg.sv
// Shared constants for the data-memory arbiter: FSM state codes, port indices, default widths.
package dm_arb_pkg;

  localparam int unsigned AW_DEF = 10;
  localparam int unsigned DW_DEF = 32;

  // FSM state codes
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_BURST1 = 1'b1;

  // Port indices into the grant vector
  localparam int unsigned P_CPU = 0;
  localparam int unsigned P_DMA = 1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone request wins; on a tie, ptr selects the winner.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt_c
);

  // Onehot winner selection
  always_comb begin
    gnt_c = req;
    if (req == 2'b11) begin
      gnt_c = ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory arbiter: shares one single-port DM between the CPU (port 0) and the
// DMA/debug loader (port 1). Grants are zero-latency; load data returns one cycle later.
// Port 1 may hold the memory for bursts of up to MAX_BURST beats.
// Optional build macro DM_ARB_CPU_PRIORITY_EN: CPU wins every tie and preempts bursts.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned AW        = AW_DEF,
  parameter int unsigned DW        = DW_DEF,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  input  logic          p1_last,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic [AW-1:0] dm_A,
  output logic [DW-1:0] dm_D,
  output logic          dm_Memwrite,
  output logic          dm_Memtoreg,
  input  logic [DW-1:0] dm_out
);

  localparam int unsigned BCW = $clog2(MAX_BURST + 1);

  logic [0:0]     state_q, state_d;
  logic           rr_ptr_q, rr_ptr_d;
  logic [BCW-1:0] beat_q, beat_d;
  logic [1:0]     rr_gnt;
  logic [1:0]     gnt;
  logic [BCW-1:0] beat_inc;

  assign beat_inc = beat_q + BCW'(1);

`ifdef DM_ARB_CPU_PRIORITY_EN
  // CPU always wins a tie; the round-robin pointer plays no part
  assign rr_gnt = p0_req ? 2'b01 : {p1_req, 1'b0};
`else
  // Fair tie-break between the two ports
  rr_pick2 u_rr_pick2 (
    .req   ({p1_req, p0_req}),
    .ptr   (rr_ptr_q),
    .gnt_c (rr_gnt)
  );
`endif

  // State, round-robin pointer and beat counter
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= 1'b0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q   <= beat_d;
    end
  end

  // Next-state and grant decode; nothing is granted while Reset is asserted
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    beat_d   = beat_q;
    gnt      = 2'b00;
    if (Reset) begin
      case (state_q)
        ST_IDLE: begin
          gnt = rr_gnt;
          if (gnt[P_CPU]) begin
            rr_ptr_d = 1'b1;
          end
          if (gnt[P_DMA]) begin
            rr_ptr_d = 1'b0;
            beat_d   = BCW'(1);
            if (!p1_last && (MAX_BURST > 1)) begin
              state_d = ST_BURST1;
            end
          end
        end
        ST_BURST1: begin
`ifdef DM_ARB_CPU_PRIORITY_EN
          if (p0_req) begin
            gnt      = 2'b01;
            rr_ptr_d = 1'b1;
            state_d  = ST_IDLE;
            beat_d   = '0;
          end else
`endif
          if (p1_req) begin
            gnt    = 2'b10;
            beat_d = beat_inc;
            if (p1_last || (beat_inc == BCW'(MAX_BURST))) begin
              state_d = ST_IDLE;
              beat_d  = '0;
            end
          end else begin
            // Burst abandoned: the CPU may take this idle slot
            state_d = ST_IDLE;
            beat_d  = '0;
            if (p0_req) begin
              gnt      = 2'b01;
              rr_ptr_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          beat_d  = '0;
        end
      endcase
    end
  end

  assign p0_gnt = gnt[P_CPU];
  assign p1_gnt = gnt[P_DMA];

  // DM pin mux: granted port drives, all zero when idle
  always_comb begin
    dm_A        = '0;
    dm_D        = '0;
    dm_Memwrite = 1'b0;
    dm_Memtoreg = 1'b0;
    if (gnt[P_CPU]) begin
      dm_A        = p0_addr;
      dm_D        = p0_wdata;
      dm_Memwrite = p0_we;
      dm_Memtoreg = ~p0_we;
    end else if (gnt[P_DMA]) begin
      dm_A        = p1_addr;
      dm_D        = p1_wdata;
      dm_Memwrite = p1_we;
      dm_Memtoreg = ~p1_we;
    end
  end

  // Load return path: capture DM data at the grant edge, flag it for one cycle
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      p0_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rvalid <= 1'b0;
      p1_rdata  <= '0;
    end else begin
      p0_rvalid <= gnt[P_CPU] & ~p0_we;
      p1_rvalid <= gnt[P_DMA] & ~p1_we;
      if (gnt[P_CPU] && !p0_we) begin
        p0_rdata <= dm_out;
      end
      if (gnt[P_DMA] && !p1_we) begin
        p1_rdata <= dm_out;
      end
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: DM model, per-cycle grant/pin checks and a load-data scoreboard.
module tb_dm_arbiter;

  logic        Clk, Reset;
  logic        p0_req, p0_we, p0_gnt, p0_rvalid;
  logic [9:0]  p0_addr;
  logic [31:0] p0_wdata, p0_rdata;
  logic        p1_req, p1_we, p1_last, p1_gnt, p1_rvalid;
  logic [9:0]  p1_addr;
  logic [31:0] p1_wdata, p1_rdata;
  logic [9:0]  dm_A;
  logic [31:0] dm_D, dm_out;
  logic        dm_Memwrite, dm_Memtoreg;

  logic [31:0] dm_mem  [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  int n_tests = 0;
  int n_fail  = 0;

  dm_arbiter #(.AW(10), .DW(32), .MAX_BURST(4)) dut (
    .Clk(Clk), .Reset(Reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_last(p1_last), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .dm_A(dm_A), .dm_D(dm_D), .dm_Memwrite(dm_Memwrite), .dm_Memtoreg(dm_Memtoreg),
    .dm_out(dm_out)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Single-port DM: combinational read, write on rising edge
  assign dm_out = dm_mem[dm_A];
  always @(posedge Clk) begin
    if (dm_Memwrite) dm_mem[dm_A] <= dm_D;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every rvalid must match the oldest expected load
  initial begin
    forever begin
      @(negedge Clk);
      if (p0_rvalid) begin
        if (q0.size() == 0) check_eq("p0_rvalid_spurious", 32'(p0_rvalid), 32'd0);
        else check_eq("p0_rdata", p0_rdata, q0.pop_front());
      end
      if (p1_rvalid) begin
        if (q1.size() == 0) check_eq("p1_rvalid_spurious", 32'(p1_rvalid), 32'd0);
        else check_eq("p1_rdata", p1_rdata, q1.pop_front());
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_gnt"}, 32'({p1_gnt, p0_gnt}), 32'd0);
    check_eq({tag, "_rvalid"}, 32'({p1_rvalid, p0_rvalid}), 32'd0);
    check_eq({tag, "_p0_rdata"}, p0_rdata, 32'd0);
    check_eq({tag, "_p1_rdata"}, p1_rdata, 32'd0);
    check_eq({tag, "_dm_ctl"}, 32'({dm_Memwrite, dm_Memtoreg}), 32'd0);
    check_eq({tag, "_dm_A"}, 32'(dm_A), 32'd0);
    check_eq({tag, "_dm_D"}, dm_D, 32'd0);
  endtask

  // One cycle: check grants and DM pins mid-cycle, record expected effects, advance
  task automatic tick(input string tag, input logic eg0, input logic eg1);
    @(negedge Clk);
    check_eq({tag, "_g0"}, 32'(p0_gnt), 32'(eg0));
    check_eq({tag, "_g1"}, 32'(p1_gnt), 32'(eg1));
    if (eg0) begin
      check_eq({tag, "_A"}, 32'(dm_A), 32'(p0_addr));
      check_eq({tag, "_D"}, dm_D, p0_wdata);
      check_eq({tag, "_wr_rd"}, 32'({dm_Memwrite, dm_Memtoreg}), 32'({p0_we, ~p0_we}));
      if (p0_we) ref_mem[p0_addr] = p0_wdata;
      else q0.push_back(ref_mem[p0_addr]);
    end else if (eg1) begin
      check_eq({tag, "_A"}, 32'(dm_A), 32'(p1_addr));
      check_eq({tag, "_D"}, dm_D, p1_wdata);
      check_eq({tag, "_wr_rd"}, 32'({dm_Memwrite, dm_Memtoreg}), 32'({p1_we, ~p1_we}));
      if (p1_we) ref_mem[p1_addr] = p1_wdata;
      else q1.push_back(ref_mem[p1_addr]);
    end else begin
      check_eq({tag, "_idle_pins"}, 32'({dm_Memwrite, dm_Memtoreg}), 32'd0);
      check_eq({tag, "_idle_A"}, 32'(dm_A), 32'd0);
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0; p1_last = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    Reset = 1'b0;
    clear_inputs();
    q0.delete();
    q1.delete();
    repeat (2) @(negedge Clk);
    check_all_zero(tag);
    @(posedge Clk);
    #1 Reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      dm_mem[i]  = 32'hA500_0000 | 32'(i);
      ref_mem[i] = 32'hA500_0000 | 32'(i);
    end
    Reset = 1'b1;
    clear_inputs();
    #2;
    do_reset("rst");

    // 1: CPU store then load of the same word
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 10'h003; p0_wdata = 32'hDEAD_BEEF;
    tick("t1_st", 1'b1, 1'b0);
    p0_we = 1'b0; p0_wdata = '0;
    tick("t1_ld", 1'b1, 1'b0);
    p0_req = 1'b0;
    tick("t1_rv", 1'b0, 1'b0);
    tick("t1_hold", 1'b0, 1'b0);
    check_eq("t1_rdata_hold", p0_rdata, 32'hDEAD_BEEF);

    // 2: both ports load continuously from reset; grants alternate starting with port 0
    do_reset("rst2");
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 10'h010;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 10'h020; p1_last = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick("t2_alt", (k % 2) == 0, (k % 2) == 1);
    end
    clear_inputs();
    tick("t2_drain", 1'b0, 1'b0);

`ifndef DM_ARB_CPU_PRIORITY_EN
    // 3: six-beat DMA store burst with the CPU waiting from beat 2
    p1_req = 1'b1; p1_we = 1'b1; p1_last = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      p1_addr = 10'(32'h40 + 32'(k) - 1); p1_wdata = 32'h1000 + 32'(k);
      if (k == 2) begin p0_req = 1'b1; p0_we = 1'b0; p0_addr = 10'h041; end
      tick("t3_burst", 1'b0, 1'b1);
    end
    p1_addr = 10'h044; p1_wdata = 32'h1005;
    tick("t3_cpu", 1'b1, 1'b0);
    p0_req = 1'b0;
    tick("t3_b5", 1'b0, 1'b1);
    p1_addr = 10'h045; p1_wdata = 32'h1006; p1_last = 1'b1;
    tick("t3_b6", 1'b0, 1'b1);
    clear_inputs();
    tick("t3_end", 1'b0, 1'b0);

    // 4: burst ended early by p1_last on beat 2; CPU granted next cycle
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 10'h045; p1_last = 1'b0;
    tick("t4_b1", 1'b0, 1'b1);
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 10'h044;
    p1_addr = 10'h046; p1_last = 1'b1;
    tick("t4_b2", 1'b0, 1'b1);
    p1_req = 1'b0; p1_last = 1'b0;
    tick("t4_cpu", 1'b1, 1'b0);
    clear_inputs();
    tick("t4_end", 1'b0, 1'b0);

    // 4b: DMA drops its request mid-burst; CPU takes that same slot
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 10'h030;
    tick("t4b_b1", 1'b0, 1'b1);
    p1_req = 1'b0; p0_req = 1'b1; p0_we = 1'b0; p0_addr = 10'h031;
    tick("t4b_cpu", 1'b1, 1'b0);
    clear_inputs();
    tick("t4b_end", 1'b0, 1'b0);
`else
    // 6: CPU request preempts a DMA burst on beat 2
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 10'h030; p1_last = 1'b0;
    tick("t6_b1", 1'b0, 1'b1);
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 10'h031;
    tick("t6_cpu", 1'b1, 1'b0);
    p0_req = 1'b0; p1_last = 1'b1;
    tick("t6_b2", 1'b0, 1'b1);
    clear_inputs();
    tick("t6_end", 1'b0, 1'b0);
`endif

    // 5: reset falls mid-burst with a DMA load outstanding and a store pending
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 10'h050; p1_last = 1'b0;
    tick("t5_b1", 1'b0, 1'b1);
    p1_we = 1'b1; p1_addr = 10'h051; p1_wdata = 32'h0BAD_0BAD;
    #1 Reset = 1'b0;
    #1;
    check_all_zero("t5_async");
    q1.delete();
    repeat (2) @(negedge Clk);
    check_all_zero("t5_hold");
    @(posedge Clk);
    #1;
    clear_inputs();
    Reset = 1'b1;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 10'h051;
    tick("t5_rd", 1'b1, 1'b0);
    p0_req = 1'b0;
    tick("t5_rv", 1'b0, 1'b0);
    tick("t5_end", 1'b0, 1'b0);

    check_eq("q0_drained", 32'(q0.size()), 32'd0);
    check_eq("q1_drained", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
